// File: rtl/tick_sequencer.sv
// tick_sequencer: programmable tick (clock-enable) generator with start/stop control and a
// shadowed period update applied on tick boundaries. Optional clk_out square wave: TICK_SQUARE_EN.
module tick_sequencer #(
    parameter int CNT_W       = 16,
    parameter int TCNT_W      = 8,
    parameter int DIV_DEFAULT = 4
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              start,
    input  logic              stop,
    output logic              tick,
    output logic [TCNT_W-1:0] tick_cnt,
    output logic              running,
    output logic              clk_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  r_div;
    logic [CNT_W-1:0]  w_div_nxt;
    logic [CNT_W-1:0]  r_shadow;
    logic [CNT_W-1:0]  w_shadow_nxt;
    logic              r_tick;
    logic              w_tick_nxt;
    logic [TCNT_W-1:0] r_tick_cnt;
    logic [TCNT_W-1:0] w_tick_cnt_nxt;

    logic [CNT_W-1:0]  w_eff;
    logic [CNT_W-1:0]  w_last;
    logic              w_boundary;
    logic              w_cfg_fire;

    // A programmed period of 0 behaves as 1, giving a continuous tick.
    assign w_eff      = (r_div == '0) ? CNT_ONE : r_div;
    assign w_last     = w_eff - CNT_ONE;
    assign w_boundary = (r_cnt == w_last);

    assign cfg_ready  = (r_state != S_PEND);
    assign w_cfg_fire = cfg_valid & cfg_ready;
    assign running    = (r_state != S_IDLE);
    assign tick       = r_tick;
    assign tick_cnt   = r_tick_cnt;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div;
        w_shadow_nxt   = r_shadow;
        w_tick_nxt     = 1'b0;
        w_tick_cnt_nxt = r_tick_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_cfg_fire) begin
                    w_div_nxt = cfg_div;
                end
                if (start && !stop) begin
                    w_state_nxt    = S_RUN;
                    w_cnt_nxt      = '0;
                    w_tick_cnt_nxt = '0;
                end
            end

            S_RUN, S_PEND: begin
                if (stop) begin
                    // Leaving RUN/PEND never loses an accepted period request.
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    if (r_state == S_PEND) begin
                        w_div_nxt = r_shadow;
                    end else if (w_cfg_fire) begin
                        w_div_nxt = cfg_div;
                    end
                end else begin
                    if (w_boundary) begin
                        w_cnt_nxt      = '0;
                        w_tick_nxt     = 1'b1;
                        w_tick_cnt_nxt = r_tick_cnt + TCNT_ONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end

                    if (r_state == S_RUN) begin
                        if (w_cfg_fire) begin
                            w_shadow_nxt = cfg_div;
                            w_state_nxt  = S_PEND;
                        end
                    end else if (w_boundary) begin
                        w_div_nxt   = r_shadow;
                        w_state_nxt = S_RUN;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div      <= CNT_W'(DIV_DEFAULT);
            r_shadow   <= '0;
            r_tick     <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div      <= w_div_nxt;
            r_shadow   <= w_shadow_nxt;
            r_tick     <= w_tick_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
        end
    end

`ifdef TICK_SQUARE_EN
    logic r_clk_out;

    // Toggles with each tick, so the square wave spans two tick periods; held low while idle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_out <= 1'b0;
        end else if (w_state_nxt == S_IDLE) begin
            r_clk_out <= 1'b0;
        end else if (w_tick_nxt) begin
            r_clk_out <= ~r_clk_out;
        end
    end

    assign clk_out = r_clk_out;
`else
    assign clk_out = 1'b0;
`endif

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed testbench for tick_sequencer: inputs driven and outputs sampled 1 time unit after
// each rising edge; expected values are hand-derived per scenario.
module tb_tick_sequencer;

    localparam int CNT_W  = 16;
    localparam int TCNT_W = 8;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_div;
    logic              start;
    logic              stop;
    logic              tick;
    logic [TCNT_W-1:0] tick_cnt;
    logic              running;
    logic              clk_out;

    int n_checks = 0;
    int n_errors = 0;

    tick_sequencer #(
        .CNT_W       (CNT_W),
        .TCNT_W      (TCNT_W),
        .DIV_DEFAULT (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .tick_cnt  (tick_cnt),
        .running   (running),
        .clk_out   (clk_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic edge_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic program_div(input logic [CNT_W-1:0] v);
        cfg_valid = 1'b1;
        cfg_div   = v;
        edge_step();
        cfg_valid = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        edge_step();
        stop = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        edge_step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        start     = 1'b0;
        stop      = 1'b0;
        #2;
        n_checks++;
        if ({tick, tick_cnt, running, cfg_ready, clk_out} !== {1'b0, 8'd0, 1'b0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_outputs got tick=%0b cnt=%0d run=%0b rdy=%0b clk_out=%0b want 0 0 0 1 0",
                     tick, tick_cnt, running, cfg_ready, clk_out);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        edge_step();
    endtask

    task automatic test_default_period();
        logic exp_clk;
        pulse_start();
        n_checks++;
        if (running !== 1'b1 || tick !== 1'b0 || tick_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL dflt_start got run=%0b tick=%0b cnt=%0d want 1 0 0", running, tick, tick_cnt);
        end
        for (int k = 1; k <= 12; k++) begin
            edge_step();
            n_checks++;
            if (tick !== (k % 4 == 0) || tick_cnt !== TCNT_W'(k / 4)) begin
                n_errors++;
                $display("FAIL dflt_tick k=%0d got tick=%0b cnt=%0d want %0b %0d",
                         k, tick, tick_cnt, (k % 4 == 0), k / 4);
            end
`ifdef TICK_SQUARE_EN
            exp_clk = ((k / 4) % 2) == 1;
`else
            exp_clk = 1'b0;
`endif
            n_checks++;
            if (clk_out !== exp_clk) begin
                n_errors++;
                $display("FAIL dflt_clk_out k=%0d got %0b want %0b", k, clk_out, exp_clk);
            end
        end
        go_idle();
        n_checks++;
        if (running !== 1'b0 || tick !== 1'b0 || tick_cnt !== 8'd3 || clk_out !== 1'b0) begin
            n_errors++;
            $display("FAIL dflt_stop got run=%0b tick=%0b cnt=%0d clk_out=%0b want 0 0 3 0",
                     running, tick, tick_cnt, clk_out);
        end
    endtask

    task automatic test_div_one();
        logic exp_clk;
        for (int v = 1; v >= 0; v--) begin
            program_div(CNT_W'(v));
            pulse_start();
            n_checks++;
            if (tick !== 1'b0 || tick_cnt !== 8'd0) begin
                n_errors++;
                $display("FAIL div%0d_start got tick=%0b cnt=%0d want 0 0", v, tick, tick_cnt);
            end
            for (int k = 1; k <= 5; k++) begin
                edge_step();
`ifdef TICK_SQUARE_EN
                exp_clk = (k % 2) == 1;
`else
                exp_clk = 1'b0;
`endif
                n_checks++;
                if (tick !== 1'b1 || tick_cnt !== TCNT_W'(k) || clk_out !== exp_clk) begin
                    n_errors++;
                    $display("FAIL div%0d_tick k=%0d got tick=%0b cnt=%0d clk_out=%0b want 1 %0d %0b",
                             v, k, tick, tick_cnt, clk_out, k, exp_clk);
                end
            end
            go_idle();
            n_checks++;
            if (tick !== 1'b0 || running !== 1'b0 || tick_cnt !== 8'd5) begin
                n_errors++;
                $display("FAIL div%0d_stop got tick=%0b run=%0b cnt=%0d want 0 0 5", v, tick, running, tick_cnt);
            end
        end
    endtask

    task automatic test_pend_update();
        program_div(CNT_W'(4));
        pulse_start();
        edge_step();
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(6);
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL pend_ready_run got %0b want 1", cfg_ready);
        end
        edge_step();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0 || tick !== 1'b0) begin
            n_errors++;
            $display("FAIL pend_accept got rdy=%0b tick=%0b want 0 0", cfg_ready, tick);
        end
        for (int k = 3; k <= 16; k++) begin
            edge_step();
            n_checks++;
            if (tick !== (k == 4 || k == 10 || k == 16)) begin
                n_errors++;
                $display("FAIL pend_tick k=%0d got %0b want %0b", k, tick, (k == 4 || k == 10 || k == 16));
            end
            if (k == 3 || k == 4) begin
                n_checks++;
                if (cfg_ready !== (k == 4)) begin
                    n_errors++;
                    $display("FAIL pend_ready k=%0d got %0b want %0b", k, cfg_ready, (k == 4));
                end
            end
        end
        n_checks++;
        if (tick_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL pend_tick_cnt got %0d want 3", tick_cnt);
        end
        go_idle();
    endtask

    task automatic test_stop_commit();
        program_div(CNT_W'(4));
        pulse_start();
        edge_step();
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(2);
        edge_step();
        cfg_valid = 1'b0;
        go_idle();
        n_checks++;
        if (running !== 1'b0 || cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL commit_stop got run=%0b rdy=%0b want 0 1", running, cfg_ready);
        end
        pulse_start();
        for (int k = 1; k <= 4; k++) begin
            edge_step();
            n_checks++;
            if (tick !== (k % 2 == 0)) begin
                n_errors++;
                $display("FAIL commit_tick k=%0d got %0b want %0b", k, tick, (k % 2 == 0));
            end
        end
        go_idle();
    endtask

    task automatic test_start_stop();
        program_div(CNT_W'(4));
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            start = (k >= 2 && k <= 4);
            edge_step();
            n_checks++;
            if (tick !== (k % 4 == 0) || tick_cnt !== TCNT_W'(k / 4) || running !== 1'b1) begin
                n_errors++;
                $display("FAIL ss_run k=%0d got tick=%0b cnt=%0d run=%0b want %0b %0d 1",
                         k, tick, tick_cnt, running, (k % 4 == 0), k / 4);
            end
        end
        start = 1'b1;
        stop  = 1'b1;
        edge_step();
        n_checks++;
        if (running !== 1'b0 || tick !== 1'b0 || tick_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL ss_both got run=%0b tick=%0b cnt=%0d want 0 0 2", running, tick, tick_cnt);
        end
        edge_step();
        n_checks++;
        if (running !== 1'b0) begin
            n_errors++;
            $display("FAIL ss_both_idle got run=%0b want 0", running);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset_mid_pend();
        pulse_start();
        for (int k = 1; k <= 5; k++) edge_step();
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(6);
        edge_step();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0 || tick_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL rst_pend_setup got rdy=%0b cnt=%0d want 0 1", cfg_ready, tick_cnt);
        end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({tick, tick_cnt, running, cfg_ready, clk_out} !== {1'b0, 8'd0, 1'b0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL rst_pend_outputs got tick=%0b cnt=%0d run=%0b rdy=%0b clk_out=%0b want 0 0 0 1 0",
                     tick, tick_cnt, running, cfg_ready, clk_out);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        edge_step();
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            edge_step();
            n_checks++;
            if (tick !== (k % 4 == 0)) begin
                n_errors++;
                $display("FAIL rst_pend_restart k=%0d got %0b want %0b", k, tick, (k % 4 == 0));
            end
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        program_div(CNT_W'(4));
        pulse_start();
        for (int k = 1; k <= 3; k++) edge_step();
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(2);
        edge_step();
        cfg_valid = 1'b0;
        n_checks++;
        if (tick !== 1'b1 || cfg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_boundary got tick=%0b rdy=%0b want 1 0", tick, cfg_ready);
        end
        for (int k = 5; k <= 12; k++) begin
            edge_step();
            n_checks++;
            if (tick !== (k == 8 || k == 10 || k == 12)) begin
                n_errors++;
                $display("FAIL b2b_tick k=%0d got %0b want %0b", k, tick, (k == 8 || k == 10 || k == 12));
            end
        end
        n_checks++;
        if (tick_cnt !== 8'd4) begin
            n_errors++;
            $display("FAIL b2b_tick_cnt got %0d want 4", tick_cnt);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_div_one();
        test_pend_update();
        test_stop_commit();
        test_start_stop();
        test_reset_mid_pend();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
